fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- Program-counter and instruction-fetch stage of the single-issue 32-bit core.
- Holds the architectural PC and drives it into the existing 32-bit PC adder (OperA = PC, OperB = 4). It consumes the adder's Result as the sequential next PC.
- Issues one outstanding read to instruction memory at a time. Presents the fetched instruction and its PC to decode through a valid/ready handshake.
- Applies branch redirects from execute and flushes any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT_CYC, 16, maximum WAIT cycles before a fetch error is declared (range 2..255).

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_o  out  32  current PC, wired to adder OperA.
- pc_plus4_i  in  32  adder Result (pc_o + 4).
- branch_taken_i  in  1  redirect pulse from execute.
- branch_target_i  in  32  redirect address; bits [1:0] are forced to 0 internally.
- stall_i  in  1  hazard-unit stall; blocks acceptance by decode.
- imem_req_o  out  1  single-cycle read request.
- imem_addr_o  out  32  read address; equals pc_o.
- imem_rvalid_i  in  1  read data valid; asserts at least 1 cycle after the request.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  instruction valid to decode.
- if_ready_i  in  1  decode ready.
- if_instr_o  out  32  fetched instruction.
- if_pc_o  out  32  PC of if_instr_o.
- fetch_err_o  out  1  sticky fetch timeout flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc = RESET_PC.
  - state = FETCH.
  - flush_pending = 0; timeout count = 0.
  - All outputs 0, except pc_o and imem_addr_o, which equal RESET_PC.
- States: FETCH, WAIT, HOLD, ERROR.
- FETCH:
  - imem_req_o = !branch_taken_i, combinational, for exactly one cycle.
  - If the request is issued, go to WAIT and clear the timeout count.
  - If branch_taken_i is high, stay in FETCH.
- WAIT:
  - The timeout count increments every cycle.
  - On imem_rvalid_i with flush_pending=0 and no branch: capture imem_rdata_i into if_instr_o and pc into if_pc_o. Set if_valid_o=1 and go to HOLD.
  - On imem_rvalid_i with flush_pending=1: discard the data, clear flush_pending, go to FETCH.
  - When the count reaches TIMEOUT_CYC without rvalid: set fetch_err_o=1 and go to ERROR.
- HOLD:
  - Holds if_instr_o and if_pc_o stable while if_valid_o=1.
  - Acceptance is if_ready_i && !stall_i.
  - On acceptance: pc <= pc_plus4_i, if_valid_o <= 0, go to FETCH.
- ERROR:
  - Terminal: no requests, if_valid_o=0, fetch_err_o held at 1.
  - Only reset exits ERROR.
- Branch (branch_taken_i=1) has priority over all events in FETCH, WAIT and HOLD:
  - pc <= {branch_target_i[31:2], 2'b00}; if_valid_o <= 0.
  - In HOLD: go to FETCH; the held instruction is dropped.
  - In WAIT with no rvalid the same cycle: set flush_pending=1, stay in WAIT, keep the timeout running.
  - In WAIT with rvalid the same cycle: discard the data, go to FETCH.
  - Ignored in ERROR.
- Back-to-back branches: the last target wins; flush_pending stays 1 (only one stale response is outstanding).
- Latency:
  - Acceptance at cycle N -> request at N+1 -> rvalid no earlier than N+2 -> if_valid_o no earlier than N+3.
  - Peak throughput is 1 instruction per 3 cycles.
- Arithmetic: the PC wraps modulo 2^32 via the adder (32'hFFFF_FFFC + 4 = 0); no local adder.
- Misaligned pc_plus4_i is not possible by construction; no check is made.
- imem_rvalid_i outside WAIT is ignored.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum {FETCH, WAIT, HOLD, ERROR}.
  - XLEN=32.
  - PC_ALIGN_MASK=32'hFFFF_FFFC.
- One sub-module, fetch_timeout_ctr: 8-bit counter with clear/enable inputs and an expire output compared against TIMEOUT_CYC.
- The PC adder stays external at the core top level.

Test Plan:
- Reset then memory latency 1, decode always ready -> requests at 0x0, 0x4, 0x8. if_pc_o follows 0x0, 0x4, 0x8 with matching if_instr_o; if_valid_o rises 3 cycles after each acceptance.
- stall_i=1 for 5 cycles while in HOLD with instr 0xDEADBEEF at 0x4 -> if_valid_o, instr and PC stay stable; no request issued; pc advances to 0x8 one cycle after stall_i drops.
- branch_taken_i to 0x100 during WAIT (response arrives 2 cycles later) -> that response is discarded, next request address is 0x100, if_pc_o=0x100.
- branch_taken_i to 0x203 in the same cycle as rvalid -> data dropped, next request address 0x200, no if_valid_o for the dropped word.
- rvalid withheld for TIMEOUT_CYC=16 cycles -> fetch_err_o=1 at cycle 16, no further imem_req_o; rst_n pulse clears it and refetches RESET_PC.
- rst_n asserted mid-WAIT, then a stale rvalid arrives after release -> the stale rvalid is ignored, the first post-reset request is at RESET_PC, and all outputs are 0 during reset.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, datapath width, PC alignment helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } fetch_state_t;

    // Instructions are word aligned; clears the two byte-offset bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting on instruction memory; flags expiry at TIMEOUT_CYC.
// Latency: expire_o is combinational from the registered count and en_i.
// Backpressure: none; clr_i wins over en_i, count saturates at 8'hFF.
// Ports: clk/rst_n clock and async reset; clr_i zero the count; en_i count this
//        cycle; expire_o high in the TIMEOUT_CYC-th enabled cycle and beyond.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // The count holds the number of enabled cycles already completed, so the
    // cycle that would bring it to TIMEOUT_CYC is the expiring one.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ">=" rather than "==": a branch can hold the FSM in WAIT past the
    // expiring cycle, and the timeout must still fire on the next one.
    assign expire_o = en_i && (cnt_q >= LAST_CNT);

endmodule

// File: rtl/fetch_pc_stage.sv
// PC register and single-outstanding instruction fetch, handing words to decode.
// Latency: acceptance at N -> request N+1 -> rvalid >= N+2 -> if_valid_o >= N+3.
// Backpressure: holds the fetched word until if_ready_i && !stall_i; branches override.
// Ports: clk/rst_n; pc_o/pc_plus4_i to/from the external PC adder; branch_taken_i/
//        branch_target_i redirect; stall_i hazard stall; imem_* instruction memory
//        read port; if_* valid/ready handshake to decode; fetch_err_o sticky timeout.
module fetch_pc_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            fetch_err_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            flush_q, flush_d;

    logic            req;
    logic            accept;
    logic            expire;
    logic [XLEN-1:0] br_tgt;

    // rst_n gates the request so nothing is issued while reset is held, even
    // though the FSM already sits in FETCH.
    assign req    = rst_n && (state_q == FETCH) && !branch_taken_i;
    assign accept = if_ready_i && !stall_i;
    assign br_tgt = align_pc(branch_target_i);

    fetch_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (req),
        .en_i     (state_q == WAIT),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        valid_d = valid_q;
        err_d   = err_q;
        flush_d = flush_q;

        case (state_q)
            FETCH: begin
                if (branch_taken_i) begin
                    pc_d = br_tgt;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (branch_taken_i) begin
                    pc_d    = br_tgt;
                    valid_d = 1'b0;
                    if (imem_rvalid_i) begin
                        // The response for the old PC lands now; nothing stale remains.
                        flush_d = 1'b0;
                        state_d = FETCH;
                    end else begin
                        // One request is outstanding at most, so one discard
                        // covers any number of back-to-back branches.
                        flush_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = FETCH;
                    end else begin
                        instr_d = imem_rdata_i;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end

            HOLD: begin
                if (branch_taken_i) begin
                    pc_d    = br_tgt;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (accept) begin
                    // Wraps modulo 2^32 in the external adder.
                    pc_d    = pc_plus4_i;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end

            ERROR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            if_pc_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            flush_q <= flush_d;
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;
    assign imem_req_o  = req;
    assign if_valid_o  = valid_q;
    assign if_instr_o  = instr_q;
    assign if_pc_o     = if_pc_q;
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External PC adder of the core.
    assign pc_plus4 = pc_o + 32'd4;

    fetch_pc_stage #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_o            (pc_o),
        .pc_plus4_i      (pc_plus4),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .stall_i         (stall),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .if_valid_o      (if_valid),
        .if_ready_i      (if_ready),
        .if_instr_o      (if_instr),
        .if_pc_o         (if_pc),
        .fetch_err_o     (fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Called in a FETCH cycle; returns in the HOLD cycle with the word presented.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        #1;
        chk1("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, a);
        chk1("fetch_valid_lo", if_valid, 1'b0);
        cyc();
        #1;
        chk1("wait_req_lo", imem_req, 1'b0);
        chk1("wait_valid_lo", if_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk1("hold_valid", if_valid, 1'b1);
        chk("hold_instr", if_instr, d);
        chk("hold_pc", if_pc, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        stall         = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        if_ready      = 1'b1;

        // Reset state
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        chk1("rst_err", fetch_err, 1'b0);
        cyc();
        rst_n = 1'b1;

        // Sequential fetch with one-cycle memory, decode ready
        fetch_one(32'h0, 32'h0000_0013);
        cyc();
        fetch_one(32'h4, 32'hDEAD_BEEF);

        // Stall in HOLD for 5 cycles
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk1("stall_valid", if_valid, 1'b1);
            chk("stall_instr", if_instr, 32'hDEAD_BEEF);
            chk("stall_ifpc", if_pc, 32'h4);
            chk1("stall_req", imem_req, 1'b0);
            chk("stall_pc", pc_o, 32'h4);
        end
        stall = 1'b0;
        cyc();
        #1;
        chk("unstall_pc", pc_o, 32'h8);
        chk1("unstall_valid", if_valid, 1'b0);
        fetch_one(32'h8, 32'h0080_0093);
        cyc();

        // Branch during WAIT, stale response two cycles later
        #1;
        chk("pre_br_addr", imem_addr, 32'hC);
        cyc();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        #1;
        chk1("br_wait_req", imem_req, 1'b0);
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("br_wait_pc", pc_o, 32'h100);
        chk1("br_wait_req2", imem_req, 1'b0);
        chk1("br_wait_valid", if_valid, 1'b0);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0001;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk1("flush_valid", if_valid, 1'b0);
        fetch_one(32'h100, 32'h1111_1111);
        cyc();

        // Branch to misaligned target coinciding with rvalid
        cyc();
        imem_rvalid   = 1'b1;
        imem_rdata    = 32'hBAD0_0002;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0203;
        cyc();
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk1("brrv_valid", if_valid, 1'b0);
        chk("brrv_pc", pc_o, 32'h200);
        fetch_one(32'h200, 32'h2222_2222);

        // Branch in HOLD beats acceptance
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("brhold_pc", pc_o, 32'h300);
        chk1("brhold_valid", if_valid, 1'b0);
        chk1("brhold_req", imem_req, 1'b1);

        // Branch in FETCH suppresses the request
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0401;
        #1;
        chk1("brfetch_req", imem_req, 1'b0);
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("brfetch_pc", pc_o, 32'h400);
        chk1("brfetch_req2", imem_req, 1'b1);

        // Timeout: 16 WAIT cycles without rvalid
        cyc();
        #1;
        chk1("to_err_w1", fetch_err, 1'b0);
        repeat (15) cyc();
        #1;
        chk1("to_err_w16", fetch_err, 1'b0);
        chk1("to_req_w16", imem_req, 1'b0);
        cyc();
        #1;
        chk1("to_err", fetch_err, 1'b1);
        chk1("to_req", imem_req, 1'b0);
        imem_rvalid   = 1'b1;
        imem_rdata    = 32'h5555_5555;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0500;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk1("err_req", imem_req, 1'b0);
            chk1("err_sticky", fetch_err, 1'b1);
            chk1("err_valid", if_valid, 1'b0);
            chk("err_pc", pc_o, 32'h400);
        end
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("errrst_err", fetch_err, 1'b0);
        chk("errrst_pc", pc_o, 32'h0);
        chk1("errrst_req", imem_req, 1'b0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk1("refetch_req", imem_req, 1'b1);
        chk("refetch_addr", imem_addr, 32'h0);

        // Reset mid-WAIT, stale rvalid after release
        cyc();
        rst_n = 1'b0;
        #1;
        chk1("midrst_req", imem_req, 1'b0);
        chk1("midrst_valid", if_valid, 1'b0);
        chk1("midrst_err", fetch_err, 1'b0);
        chk("midrst_pc", pc_o, 32'h0);
        chk("midrst_instr", if_instr, 32'h0);
        chk("midrst_ifpc", if_pc, 32'h0);
        cyc();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_7777;
        #1;
        chk1("post_req", imem_req, 1'b1);
        chk("post_addr", imem_addr, 32'h0);
        chk1("post_valid", if_valid, 1'b0);
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk1("stale_valid", if_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk1("post_hold_valid", if_valid, 1'b1);
        chk("post_hold_instr", if_instr, 32'h0000_0033);
        chk("post_hold_pc", if_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
